apu_reg_loader: RTL and testbench
=================================

# apu_reg_loader

Serial register-write controller for the chiptune core. It takes bytes from the UART receiver and parses them as two-byte register-write packets. Completed writes are queued in a small FIFO and presented to the APU register bank over a valid/ready handshake. It also drives the status LEDs: `link` shows serial activity and `blink` toggles on frame-sync markers.

## Interface
- `CLKRATE`, default 12_000_000: oscillator frequency in Hz; documentation and derivation only.
- `LINK_TIMEOUT`, default 1_200_000: idle cycles (100 ms at 12 MHz) before `link` drops and a half-received packet is abandoned.
- `FIFO_DEPTH`, default 4: queued register writes; must be a power of two, ≥2.
- `osc` input 1: clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `rx_data` input 8: received byte, valid only when `rx_valid` is high.
- `rx_valid` input 1: one-cycle strobe per received byte.
- `reg_ready` input 1: register bank accepts the presented write this cycle.
- `reg_we` output 1: write request; `reg_addr`/`reg_data` are valid while high.
- `reg_addr` output 5: APU register index 0–23 (maps $4000–$4017).
- `reg_data` output 8: register value.
- `link` output 1: serial activity indicator.
- `blink` output 1: frame-sync toggle.
- `overflow` output 1: sticky; a completed packet was dropped because the FIFO was full.

## Operation
- Byte classes:
  - Header: bit7=1, address = bits[4:0].
  - Data: bit7=0 is not required; in state DATA any byte is data. In state IDLE, a byte with bit7=0 is discarded.
- Parser FSM, states IDLE and DATA:
  - IDLE + header → DATA; latch the address.
  - IDLE + non-header → IDLE; byte discarded.
  - DATA + any byte → IDLE; packet complete with data = byte. In DATA, bit7 of the data byte is a data bit.
  - DATA + timeout (no `rx_valid` for LINK_TIMEOUT cycles) → IDLE; packet abandoned, nothing pushed.
- On packet completion:
  - Address 0–23: push {addr, data} to the FIFO.
  - Address 31 (header 0x9F): frame sync. Toggle `blink`; data is ignored and nothing is pushed.
  - Addresses 24–30: drop silently.
- FIFO push:
  - Accepted when not full, or when full and a pop occurs in the same cycle.
  - Otherwise the packet is dropped and `overflow` is set. `overflow` clears only on reset.
- Drain:
  - `reg_we` = FIFO not empty; `reg_addr`/`reg_data` = FIFO head.
  - Pop when `reg_we && reg_ready`.
  - Head values are stable while `reg_we` is high and `reg_ready` is low.
- Link counter:
  - Reloads to LINK_TIMEOUT on every `rx_valid`; otherwise decrements to 0 and saturates there.
  - `link` = counter ≠ 0.
  - Width: $clog2(LINK_TIMEOUT+1).
- FIFO pointers are $clog2(FIFO_DEPTH)+1 bits and wrap naturally. Full is defined as MSBs differ and LSBs equal.

## Timing
- Reset values: `reg_we`=0, `reg_addr`=0, `reg_data`=0, `link`=0, `blink`=0, `overflow`=0. FSM resets to IDLE and the FIFO to empty.
- Reset is asynchronous. Assertion mid-packet or mid-handshake immediately clears all state; queued writes are lost.
- Latency from the data byte's `rx_valid` in cycle N:
  - `reg_we` is high in cycle N+1 if the FIFO was empty.
  - A `blink` toggle is visible in N+1.
- The first `rx_valid` after idle sets `link` in the next cycle.
- `link` falls exactly LINK_TIMEOUT cycles after the last `rx_valid`. The timeout abandon of a DATA-state packet occurs in that same cycle.
- Maximum throughput is one write per cycle. Serial input supplies at most one packet per ~2 ms at 9600 baud, so overflow only occurs under sustained `reg_ready`=0.
- Simultaneous events:
  - Push and pop in the same cycle: occupancy unchanged, head advances.
  - `rx_valid` on the timeout cycle: the byte is processed and the timeout is ignored.

## Test plan
- Reset, then bytes 0x80, 0x3F with `reg_ready`=1 → one cycle of `reg_we` with `reg_addr`=0, `reg_data`=0x3F; `link`=1.
- Bytes 0x83, 0xA5 → write addr 3, data 0xA5 (bit7 treated as data). A lone 0x12 in IDLE → no write.
- Hold `reg_ready`=0 and send 5 packets to addresses 0–4 → FIFO holds 4, the 5th is dropped, `overflow`=1. Release `reg_ready` → writes 0,1,2,3 drain in order, one per cycle.
- Header 0x9F, then 0x00, sent twice → `blink` goes 0→1→0 and `reg_we` never asserts. Header 0x98 (addr 24) with data → no write.
- Send 0x81, then idle LINK_TIMEOUT cycles, then 0x55 → no write occurs; `link` falls exactly LINK_TIMEOUT cycles after the 0x81 strobe.
- Assert `rst_n`=0 between header 0x84 and its data byte, release, then send 0x22 → no write; all outputs return to their reset values.

Source files
------------

// File: rtl/apu_reg_loader.sv
`default_nettype none
// ============================================================================
// Module   : apu_reg_loader
// Purpose  : Serial register-write controller for the chiptune core. Parses
//            UART bytes as two-byte {header, data} packets, queues completed
//            register writes in a small FIFO and drains them to the APU
//            register bank over a valid/ready handshake. Also drives the
//            serial-activity (link) and frame-sync (blink) LEDs.
// Ports    : osc_i        - clock
//            rst_ni       - asynchronous active-low reset
//            rx_data_i    - received byte (valid with rx_valid_i)
//            rx_valid_i   - one-cycle strobe per received byte
//            reg_ready_i  - register bank accepts the presented write
//            reg_we_o     - write request (FIFO not empty)
//            reg_addr_o   - APU register index 0..23 (FIFO head)
//            reg_data_o   - register value (FIFO head)
//            link_o       - serial activity indicator
//            blink_o      - toggles on every frame-sync packet
//            overflow_o   - sticky: a completed write was dropped (FIFO full)
// Revision : 1.0 - initial release
// ============================================================================
module apu_reg_loader #(
  parameter int CLKRATE      = 12_000_000,
  parameter int LINK_TIMEOUT = 1_200_000,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       osc_i,
  input  logic       rst_ni,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  input  logic       reg_ready_i,
  output logic       reg_we_o,
  output logic [4:0] reg_addr_o,
  output logic [7:0] reg_data_o,
  output logic       link_o,
  output logic       blink_o,
  output logic       overflow_o
);

  localparam int LW = $clog2(LINK_TIMEOUT + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  localparam logic [LW-1:0] LINK_RELOAD = LW'(LINK_TIMEOUT);
  localparam logic [4:0]    ADDR_LIMIT  = 5'd24;
  localparam logic [4:0]    ADDR_SYNC   = 5'd31;

  // Elaboration-time parameter sanity checks.
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("apu_reg_loader: FIFO_DEPTH must be a power of two >= 2");
  end
  if (CLKRATE <= 0 || LINK_TIMEOUT < 1) begin : g_bad_timing
    $error("apu_reg_loader: CLKRATE and LINK_TIMEOUT must be positive");
  end

  // --------------------------------------------------------------------------
  // Link activity counter
  // --------------------------------------------------------------------------
  logic [LW-1:0] link_cnt_q, link_cnt_d;

  always_comb begin
    link_cnt_d = link_cnt_q;
    if (rx_valid_i) begin
      link_cnt_d = LINK_RELOAD;
    end else if (link_cnt_q != '0) begin
      link_cnt_d = link_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge osc_i or negedge rst_ni) begin
    if (!rst_ni) begin
      link_cnt_q <= '0;
    end else begin
      link_cnt_q <= link_cnt_d;
    end
  end

  assign link_o = (link_cnt_q != '0);

  // The last idle cycle before link drops: counter is about to reach zero.
  logic timeout_tick;
  assign timeout_tick = !rx_valid_i && (link_cnt_q <= LW'(1));

  // --------------------------------------------------------------------------
  // Packet parser FSM
  // --------------------------------------------------------------------------
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_DATA = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] addr_q, addr_d;
  logic       pkt_done;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    pkt_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Bytes with bit7 clear are discarded while waiting for a header.
        if (rx_valid_i && rx_data_i[7]) begin
          state_d = ST_DATA;
          addr_d  = rx_data_i[4:0];
        end
      end
      ST_DATA: begin
        // Any byte completes the packet; a byte arriving on the timeout
        // cycle wins over the abandon.
        if (rx_valid_i) begin
          state_d  = ST_IDLE;
          pkt_done = 1'b1;
        end else if (timeout_tick) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge osc_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  logic push_req;
  logic frame_sync;

  assign push_req   = pkt_done && (addr_q < ADDR_LIMIT);
  assign frame_sync = pkt_done && (addr_q == ADDR_SYNC);

  // --------------------------------------------------------------------------
  // Blink toggle and sticky overflow
  // --------------------------------------------------------------------------
  logic blink_q, blink_d;
  logic overflow_q, overflow_d;
  logic push_ok;

  always_comb begin
    blink_d    = blink_q ^ frame_sync;
    overflow_d = overflow_q | (push_req && !push_ok);
  end

  always_ff @(posedge osc_i or negedge rst_ni) begin
    if (!rst_ni) begin
      blink_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      blink_q    <= blink_d;
      overflow_q <= overflow_d;
    end
  end

  assign blink_o    = blink_q;
  assign overflow_o = overflow_q;

  // --------------------------------------------------------------------------
  // Write FIFO
  // --------------------------------------------------------------------------
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]    mem_addr_q [FIFO_DEPTH];
  logic [7:0]    mem_data_q [FIFO_DEPTH];
  logic          fifo_empty;
  logic          fifo_full;
  logic          pop;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign pop     = !fifo_empty && reg_ready_i;
  // A full FIFO still accepts a push when the head is leaving this cycle.
  assign push_ok = push_req && (!fifo_full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge osc_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is reset so the idle head reads as zero.
  always_ff @(posedge osc_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_addr_q[i] <= '0;
        mem_data_q[i] <= '0;
      end
    end else if (push_ok) begin
      mem_addr_q[wr_ptr_q[AW-1:0]] <= addr_q;
      mem_data_q[wr_ptr_q[AW-1:0]] <= rx_data_i;
    end
  end

  assign reg_we_o   = !fifo_empty;
  assign reg_addr_o = mem_addr_q[rd_ptr_q[AW-1:0]];
  assign reg_data_o = mem_data_q[rd_ptr_q[AW-1:0]];

endmodule
`default_nettype wire

// File: tb/tb_apu_reg_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_apu_reg_loader
// Purpose  : Self-checking testbench for apu_reg_loader. A table of per-cycle
//            {inputs, expected outputs} records covers basic writes, header
//            filtering, frame sync and overflow/drain; hand-written sequences
//            cover link timeout, async reset and push-while-full.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apu_reg_loader;

  localparam int LT = 20;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       reg_ready;
  logic       reg_we;
  logic [4:0] reg_addr;
  logic [7:0] reg_data;
  logic       link;
  logic       blink;
  logic       overflow;

  int checks;
  int failures;

  apu_reg_loader #(
    .CLKRATE      (12_000_000),
    .LINK_TIMEOUT (LT),
    .FIFO_DEPTH   (4)
  ) dut (
    .osc_i       (clk),
    .rst_ni      (rst_n),
    .rx_data_i   (rx_data),
    .rx_valid_i  (rx_valid),
    .reg_ready_i (reg_ready),
    .reg_we_o    (reg_we),
    .reg_addr_o  (reg_addr),
    .reg_data_o  (reg_data),
    .link_o      (link),
    .blink_o     (blink),
    .overflow_o  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (actual=running required=finished)");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       rv;
    logic [7:0] d;
    logic       rdy;
    logic       we;
    logic [4:0] a;
    logic [7:0] dd;
    logic       bl;
    logic       ov;
  } vec_t;

  function automatic vec_t v(logic rv, logic [7:0] d, logic rdy, logic we,
                             logic [4:0] a, logic [7:0] dd, logic bl, logic ov);
    vec_t r;
    r.rv = rv; r.d = d; r.rdy = rdy; r.we = we;
    r.a = a; r.dd = dd; r.bl = bl; r.ov = ov;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Apply inputs for one cycle, then sample #1 after the edge.
  task automatic tick(input logic rv, input logic [7:0] d, input logic rdy);
    rx_valid  = rv;
    rx_data   = d;
    reg_ready = rdy;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  vec_t vecs[30];

  initial begin
    int n;
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    reg_ready = 1'b1;

    // --- table of cycle-by-cycle vectors ---
    vecs[0]  = v(1, 8'h80, 1, 0, 0, 8'h00, 0, 0);
    vecs[1]  = v(1, 8'h3F, 1, 1, 0, 8'h3F, 0, 0);
    vecs[2]  = v(0, 8'h00, 1, 0, 0, 8'h00, 0, 0);
    vecs[3]  = v(1, 8'h83, 1, 0, 0, 8'h00, 0, 0);
    vecs[4]  = v(1, 8'hA5, 1, 1, 3, 8'hA5, 0, 0);
    vecs[5]  = v(0, 8'h00, 1, 0, 0, 8'h00, 0, 0);
    vecs[6]  = v(1, 8'h12, 1, 0, 0, 8'h00, 0, 0);
    vecs[7]  = v(0, 8'h00, 1, 0, 0, 8'h00, 0, 0);
    vecs[8]  = v(1, 8'h9F, 1, 0, 0, 8'h00, 0, 0);
    vecs[9]  = v(1, 8'h00, 1, 0, 0, 8'h00, 1, 0);
    vecs[10] = v(1, 8'h9F, 1, 0, 0, 8'h00, 1, 0);
    vecs[11] = v(1, 8'h00, 1, 0, 0, 8'h00, 0, 0);
    vecs[12] = v(1, 8'h98, 1, 0, 0, 8'h00, 0, 0);
    vecs[13] = v(1, 8'h55, 1, 0, 0, 8'h00, 0, 0);
    vecs[14] = v(0, 8'h00, 1, 0, 0, 8'h00, 0, 0);
    vecs[15] = v(1, 8'h80, 0, 0, 0, 8'h00, 0, 0);
    vecs[16] = v(1, 8'h10, 0, 1, 0, 8'h10, 0, 0);
    vecs[17] = v(1, 8'h81, 0, 1, 0, 8'h10, 0, 0);
    vecs[18] = v(1, 8'h11, 0, 1, 0, 8'h10, 0, 0);
    vecs[19] = v(1, 8'h82, 0, 1, 0, 8'h10, 0, 0);
    vecs[20] = v(1, 8'h12, 0, 1, 0, 8'h10, 0, 0);
    vecs[21] = v(1, 8'h83, 0, 1, 0, 8'h10, 0, 0);
    vecs[22] = v(1, 8'h13, 0, 1, 0, 8'h10, 0, 0);
    vecs[23] = v(1, 8'h84, 0, 1, 0, 8'h10, 0, 0);
    vecs[24] = v(1, 8'h14, 0, 1, 0, 8'h10, 0, 1);
    vecs[25] = v(0, 8'h00, 1, 1, 1, 8'h11, 0, 1);
    vecs[26] = v(0, 8'h00, 1, 1, 2, 8'h12, 0, 1);
    vecs[27] = v(0, 8'h00, 1, 1, 3, 8'h13, 0, 1);
    vecs[28] = v(0, 8'h00, 1, 0, 0, 8'h00, 0, 1);
    vecs[29] = v(0, 8'h00, 1, 0, 0, 8'h00, 0, 1);

    // --- reset values ---
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we",   32'(reg_we),   32'h0);
    chk("rst_addr", 32'(reg_addr), 32'h0);
    chk("rst_data", 32'(reg_data), 32'h0);
    chk("rst_link", 32'(link),     32'h0);
    chk("rst_blink", 32'(blink),   32'h0);
    chk("rst_ovf",  32'(overflow), 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // --- table-driven section ---
    for (int i = 0; i < 30; i++) begin
      tick(vecs[i].rv, vecs[i].d, vecs[i].rdy);
      chk($sformatf("v%0d_we", i), 32'(reg_we), 32'(vecs[i].we));
      if (vecs[i].we) begin
        chk($sformatf("v%0d_addr", i), 32'(reg_addr), 32'(vecs[i].a));
        chk($sformatf("v%0d_data", i), 32'(reg_data), 32'(vecs[i].dd));
      end
      chk($sformatf("v%0d_blink", i), 32'(blink),    32'(vecs[i].bl));
      chk($sformatf("v%0d_ovf", i),   32'(overflow), 32'(vecs[i].ov));
      chk($sformatf("v%0d_link", i),  32'(link),     32'h1);
    end

    // --- link timeout: exact width and abandon of a half packet ---
    repeat (LT + 2) tick(0, 8'h00, 1);
    chk("link_idle", 32'(link), 32'h0);
    tick(1, 8'h81, 1);
    n = 0;
    while (link && n < 4 * LT) begin
      n++;
      tick(0, 8'h00, 1);
    end
    chk("link_width", 32'(n), 32'(LT));
    tick(1, 8'h55, 1);
    chk("abandon_we", 32'(reg_we), 32'h0);
    tick(0, 8'h00, 1);
    chk("abandon_we2", 32'(reg_we), 32'h0);

    // --- byte arriving on the timeout cycle is still data ---
    repeat (LT + 2) tick(0, 8'h00, 1);
    tick(1, 8'h81, 1);
    repeat (LT - 1) tick(0, 8'h00, 1);
    tick(1, 8'h55, 1);
    chk("tocyc_we",   32'(reg_we),   32'h1);
    chk("tocyc_addr", 32'(reg_addr), 32'h1);
    chk("tocyc_data", 32'(reg_data), 32'h55);
    tick(0, 8'h00, 1);
    chk("tocyc_drain", 32'(reg_we), 32'h0);

    // --- async reset between header and data ---
    tick(1, 8'h9F, 1);
    tick(1, 8'h00, 1);
    chk("pre_rst_blink", 32'(blink), 32'h1);
    tick(1, 8'h84, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_we",    32'(reg_we),   32'h0);
    chk("arst_addr",  32'(reg_addr), 32'h0);
    chk("arst_data",  32'(reg_data), 32'h0);
    chk("arst_link",  32'(link),     32'h0);
    chk("arst_blink", 32'(blink),    32'h0);
    chk("arst_ovf",   32'(overflow), 32'h0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tick(1, 8'h22, 1);
    chk("post_rst_we",   32'(reg_we), 32'h0);
    chk("post_rst_link", 32'(link),   32'h1);
    tick(0, 8'h00, 1);
    chk("post_rst_we2",  32'(reg_we),   32'h0);
    chk("post_rst_ovf",  32'(overflow), 32'h0);

    // --- push accepted while full because of a same-cycle pop ---
    for (int k = 0; k < 4; k++) begin
      tick(1, 8'h85 + 8'(k), 0);
      tick(1, 8'h50 + 8'(k), 0);
    end
    chk("full_we",   32'(reg_we),   32'h1);
    chk("full_addr", 32'(reg_addr), 32'h5);
    tick(1, 8'h89, 0);
    tick(1, 8'h59, 1);
    chk("pp_ovf",  32'(overflow), 32'h0);
    chk("pp_we",   32'(reg_we),   32'h1);
    chk("pp_addr", 32'(reg_addr), 32'h6);
    chk("pp_data", 32'(reg_data), 32'h51);
    tick(0, 8'h00, 1);
    chk("pp_a7", 32'({reg_addr, reg_data}), 32'({5'd7, 8'h52}));
    tick(0, 8'h00, 1);
    chk("pp_a8", 32'({reg_addr, reg_data}), 32'({5'd8, 8'h53}));
    tick(0, 8'h00, 1);
    chk("pp_a9", 32'({reg_addr, reg_data}), 32'({5'd9, 8'h59}));
    chk("pp_a9_we", 32'(reg_we), 32'h1);
    tick(0, 8'h00, 1);
    chk("pp_empty", 32'(reg_we), 32'h0);
    chk("pp_ovf_end", 32'(overflow), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
